// File: rtl/alu_issue_seq.sv
// Issue sequencer for the 3-bit ALU: 4-entry operand file, timed execute window,
// result capture with writeback, and valid/ready handshakes on both sides.
module alu_issue_seq #(
   parameter int WIDTH       = 3,
   parameter int EXEC_CYCLES = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_load,
   input  logic [1:0]       in_op,
   input  logic [1:0]       in_rd,
   input  logic [1:0]       in_rs1,
   input  logic [1:0]       in_rs2,
   input  logic [WIDTH-1:0] in_imm,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [1:0]       alu_op,
   input  logic [WIDTH-1:0] alu_r,
   input  logic             alu_cf,
   input  logic             alu_sf,
   input  logic             alu_zf,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_r,
   output logic             out_cf,
   output logic             out_sf,
   output logic             out_zf,
   input  logic [1:0]       dbg_addr,
   output logic [WIDTH-1:0] dbg_data
);

   localparam int             CNT_W    = 3;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(EXEC_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [WIDTH-1:0] rf_q [4];
   logic [WIDTH-1:0] alu_a_q, alu_a_d;
   logic [WIDTH-1:0] alu_b_q, alu_b_d;
   logic [1:0]       alu_op_q, alu_op_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       rd_q, rd_d;
   logic [WIDTH-1:0] out_r_q, out_r_d;
   logic             out_cf_q, out_cf_d;
   logic             out_sf_q, out_sf_d;
   logic             out_zf_q, out_zf_d;

   logic             accept;
   logic             acc_load;
   logic             acc_op;
   logic             capture;
   logic             resp_done;
   logic             wr_en;
   logic [1:0]       wr_addr;
   logic [WIDTH-1:0] wr_data;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- FSM: next-state logic ----------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (acc_load) begin
               state_d = S_RESP;
            end else if (acc_op) begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            if (capture) begin
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            if (resp_done) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs and control strobes ----------------
   always_comb begin
      in_ready  = (state_q == S_IDLE);
      out_valid = (state_q == S_RESP);
      accept    = in_valid && in_ready;
      acc_load  = accept && in_load;
      acc_op    = accept && !in_load;
      capture   = (state_q == S_EXEC) && (cnt_q == '0);
      resp_done = out_valid && out_ready;
      wr_en     = acc_load || capture;
      wr_addr   = acc_load ? in_rd : rd_q;
      wr_data   = acc_load ? in_imm : alu_r;
   end

   // ---------------- datapath next-state ----------------
   always_comb begin
      alu_a_d  = alu_a_q;
      alu_b_d  = alu_b_q;
      alu_op_d = alu_op_q;
      cnt_d    = cnt_q;
      rd_d     = rd_q;
      out_r_d  = out_r_q;
      out_cf_d = out_cf_q;
      out_sf_d = out_sf_q;
      out_zf_d = out_zf_q;

      // Operands are read before this edge's writeback, so rd==rs sees the old value.
      if (acc_op) begin
         alu_a_d  = rf_q[in_rs1];
         alu_b_d  = rf_q[in_rs2];
         alu_op_d = in_op;
         cnt_d    = CNT_INIT;
         rd_d     = in_rd;
      end else if ((state_q == S_EXEC) && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end

      if (acc_load) begin
         out_r_d  = in_imm;
         out_cf_d = 1'b0;
         out_sf_d = in_imm[WIDTH-1];
         out_zf_d = (in_imm == '0);
      end else if (capture) begin
         out_r_d  = alu_r;
         out_cf_d = alu_cf;
         out_sf_d = alu_sf;
         out_zf_d = alu_zf;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_a_q  <= '0;
         alu_b_q  <= '0;
         alu_op_q <= '0;
         cnt_q    <= '0;
         rd_q     <= '0;
         out_r_q  <= '0;
         out_cf_q <= 1'b0;
         out_sf_q <= 1'b0;
         out_zf_q <= 1'b0;
      end else begin
         alu_a_q  <= alu_a_d;
         alu_b_q  <= alu_b_d;
         alu_op_q <= alu_op_d;
         cnt_q    <= cnt_d;
         rd_q     <= rd_d;
         out_r_q  <= out_r_d;
         out_cf_q <= out_cf_d;
         out_sf_q <= out_sf_d;
         out_zf_q <= out_zf_d;
      end
   end

   // ---------------- register file ----------------
   for (genvar gi = 0; gi < 4; gi++) begin : g_rf
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            rf_q[gi] <= '0;
         end else if (wr_en && (wr_addr == 2'(gi))) begin
            rf_q[gi] <= wr_data;
         end
      end
   end

   assign dbg_data = rf_q[dbg_addr];

   assign alu_a  = alu_a_q;
   assign alu_b  = alu_b_q;
   assign alu_op = alu_op_q;
   assign out_r  = out_r_q;
   assign out_cf = out_cf_q;
   assign out_sf = out_sf_q;
   assign out_zf = out_zf_q;

endmodule

// File: tb/tb_alu_issue_seq.sv
// Bench for alu_issue_seq: two instances (EXEC_CYCLES=1 and 4) driven against a
// register-file model and a behavioural 3-bit ALU.
module tb_alu_issue_seq;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid [2];
   logic       in_ready [2];
   logic       in_load [2];
   logic [1:0] in_op [2];
   logic [1:0] in_rd [2];
   logic [1:0] in_rs1 [2];
   logic [1:0] in_rs2 [2];
   logic [2:0] in_imm [2];
   logic [2:0] alu_a [2];
   logic [2:0] alu_b [2];
   logic [1:0] alu_op [2];
   logic [2:0] alu_r [2];
   logic       alu_cf [2];
   logic       alu_sf [2];
   logic       alu_zf [2];
   logic       out_valid [2];
   logic       out_ready [2];
   logic [2:0] out_r [2];
   logic       out_cf [2];
   logic       out_sf [2];
   logic       out_zf [2];
   logic [1:0] dbg_addr [2];
   logic [2:0] dbg_data [2];

   int total = 0;
   int passed = 0;

   logic [2:0] mrf [2][4];
   logic [2:0] ma [2];
   logic [2:0] mb [2];
   logic [1:0] mop [2];
   time        last_acc [2];

   always #5 clk = ~clk;

   // Attached ALU: 00 add, 01 sub (CF=borrow), 10 and, 11 xor. Returns {cf,sf,zf,r}.
   function automatic logic [5:0] alu_fn(input logic [2:0] a, input logic [2:0] b, input logic [1:0] op);
      int s;
      int r;
      int cf;
      cf = 0;
      case (op)
         2'b00: begin s = int'(a) + int'(b); r = s % 8; cf = (s > 7) ? 1 : 0; end
         2'b01: begin s = int'(a) - int'(b); r = (s + 8) % 8; cf = (s < 0) ? 1 : 0; end
         2'b10: r = int'(a & b);
         default: r = int'(a ^ b);
      endcase
      return {cf[0], r[2], (r == 0), r[2:0]};
   endfunction

   assign {alu_cf[0], alu_sf[0], alu_zf[0], alu_r[0]} = alu_fn(alu_a[0], alu_b[0], alu_op[0]);
   assign {alu_cf[1], alu_sf[1], alu_zf[1], alu_r[1]} = alu_fn(alu_a[1], alu_b[1], alu_op[1]);

   alu_issue_seq #(.WIDTH(3), .EXEC_CYCLES(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_load(in_load[0]), .in_op(in_op[0]),
      .in_rd(in_rd[0]), .in_rs1(in_rs1[0]), .in_rs2(in_rs2[0]), .in_imm(in_imm[0]),
      .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_op(alu_op[0]),
      .alu_r(alu_r[0]), .alu_cf(alu_cf[0]), .alu_sf(alu_sf[0]), .alu_zf(alu_zf[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_r(out_r[0]),
      .out_cf(out_cf[0]), .out_sf(out_sf[0]), .out_zf(out_zf[0]),
      .dbg_addr(dbg_addr[0]), .dbg_data(dbg_data[0])
   );

   alu_issue_seq #(.WIDTH(3), .EXEC_CYCLES(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_load(in_load[1]), .in_op(in_op[1]),
      .in_rd(in_rd[1]), .in_rs1(in_rs1[1]), .in_rs2(in_rs2[1]), .in_imm(in_imm[1]),
      .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_op(alu_op[1]),
      .alu_r(alu_r[1]), .alu_cf(alu_cf[1]), .alu_sf(alu_sf[1]), .alu_zf(alu_zf[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_r(out_r[1]),
      .out_cf(out_cf[1]), .out_sf(out_sf[1]), .out_zf(out_zf[1]),
      .dbg_addr(dbg_addr[1]), .dbg_data(dbg_data[1])
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic int exec_of(input int k);
      return (k == 0) ? 1 : 4;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 4; i++) mrf[k][i] = '0;
         ma[k] = '0; mb[k] = '0; mop[k] = '0;
      end
   endtask

   task automatic check_dbg(input int k, input logic [1:0] addr, input string tag);
      dbg_addr[k] = addr;
      #1;
      chk(tag, 32'(dbg_data[k]), 32'(mrf[k][addr]));
   endtask

   // Called just after a negedge with the instance idle; returns just after a negedge.
   task automatic issue(input int k, input bit ld, input logic [1:0] op, input logic [1:0] rd,
                        input logic [1:0] rs1, input logic [1:0] rs2, input logic [2:0] imm,
                        input int delay, input bit pulse);
      logic [5:0] res;
      int cnt;
      logic [1:0] prd;
      chk("in_ready_idle", 32'(in_ready[k]), 32'd1);
      in_valid[k] = 1'b1; in_load[k] = ld; in_op[k] = op;
      in_rd[k] = rd; in_rs1[k] = rs1; in_rs2[k] = rs2; in_imm[k] = imm;
      if (ld) begin
         res = {1'b0, imm[2], (imm == 3'd0), imm};
      end else begin
         ma[k] = mrf[k][rs1]; mb[k] = mrf[k][rs2]; mop[k] = op;
         res = alu_fn(ma[k], mb[k], op);
      end
      @(negedge clk);
      last_acc[k] = $time - 5;
      in_valid[k] = 1'b0;
      cnt = 1;
      while (!out_valid[k] && cnt < 20) begin
         chk("exec_alu_a", 32'(alu_a[k]), 32'(ma[k]));
         chk("exec_alu_b", 32'(alu_b[k]), 32'(mb[k]));
         chk("exec_alu_op", 32'(alu_op[k]), 32'(mop[k]));
         @(negedge clk);
         cnt++;
      end
      chk("latency", 32'(cnt), 32'(ld ? 1 : exec_of(k) + 1));
      chk("out_valid", 32'(out_valid[k]), 32'd1);
      chk("in_ready_resp", 32'(in_ready[k]), 32'd0);
      chk("out_r", 32'(out_r[k]), 32'(res[2:0]));
      chk("out_cf", 32'(out_cf[k]), 32'(res[5]));
      chk("out_sf", 32'(out_sf[k]), 32'(res[4]));
      chk("out_zf", 32'(out_zf[k]), 32'(res[3]));
      chk("alu_a_hold", 32'(alu_a[k]), 32'(ma[k]));
      chk("alu_op_hold", 32'(alu_op[k]), 32'(mop[k]));
      mrf[k][rd] = res[2:0];
      prd = rd ^ 2'd1;
      for (int d = 0; d < delay; d++) begin
         if (pulse && d == 1) begin
            in_valid[k] = 1'b1; in_load[k] = 1'b1; in_rd[k] = prd; in_imm[k] = ~mrf[k][prd];
         end
         @(negedge clk);
         in_valid[k] = 1'b0;
         chk("bp_out_valid", 32'(out_valid[k]), 32'd1);
         chk("bp_out_r", 32'(out_r[k]), 32'(res[2:0]));
         chk("bp_in_ready", 32'(in_ready[k]), 32'd0);
      end
      out_ready[k] = 1'b1;
      @(negedge clk);
      out_ready[k] = 1'b0;
      chk("out_valid_drop", 32'(out_valid[k]), 32'd0);
      check_dbg(k, rd, "rf_writeback");
      if (pulse) check_dbg(k, prd, "rf_pulse_ignored");
      $display("txn k=%0d ld=%0d op=%0d rd=%0d rs1=%0d rs2=%0d imm=%0d -> r=%0d cf=%0d sf=%0d zf=%0d",
               k, ld, op, rd, rs1, rs2, imm, out_r[k], out_cf[k], out_sf[k], out_zf[k]);
   endtask

   task automatic check_reset_state(input string tag);
      for (int k = 0; k < 2; k++) begin
         chk({tag, "_out_valid"}, 32'(out_valid[k]), 32'd0);
         chk({tag, "_in_ready"}, 32'(in_ready[k]), 32'd1);
         chk({tag, "_alu_a"}, 32'(alu_a[k]), 32'd0);
         chk({tag, "_alu_b"}, 32'(alu_b[k]), 32'd0);
         chk({tag, "_alu_op"}, 32'(alu_op[k]), 32'd0);
         chk({tag, "_out_r"}, 32'(out_r[k]), 32'd0);
         for (int i = 0; i < 4; i++) begin
            dbg_addr[k] = 2'(i);
            #1;
            chk({tag, "_rf"}, 32'(dbg_data[k]), 32'd0);
         end
      end
   endtask

   initial begin
      time t0;
      for (int k = 0; k < 2; k++) begin
         in_valid[k] = 0; in_load[k] = 0; in_op[k] = 0; in_rd[k] = 0; in_rs1[k] = 0;
         in_rs2[k] = 0; in_imm[k] = 0; out_ready[k] = 0; dbg_addr[k] = 0; last_acc[k] = 0;
      end
      model_reset();
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_reset_state("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Load/add
      issue(0, 1, 2'b00, 2'd0, 2'd0, 2'd0, 3'b100, 0, 0);
      issue(0, 1, 2'b00, 2'd1, 2'd0, 2'd0, 3'b011, 0, 0);
      issue(0, 0, 2'b00, 2'd2, 2'd0, 2'd1, 3'd0, 0, 0);
      chk("add_alu_a", 32'(alu_a[0]), 32'b100);
      chk("add_alu_b", 32'(alu_b[0]), 32'b011);
      chk("add_out_r", 32'(out_r[0]), 32'b111);
      chk("add_rf2", 32'(dbg_data[0]), 32'b111);

      // Overflow, then a load must not disturb the ALU operand registers
      issue(0, 1, 2'b00, 2'd3, 2'd0, 2'd0, 3'b111, 0, 0);
      issue(0, 0, 2'b00, 2'd3, 2'd3, 2'd3, 3'd0, 0, 0);
      chk("ovf_out_r", 32'(out_r[0]), 32'b110);
      chk("ovf_out_cf", 32'(out_cf[0]), 32'd1);
      issue(0, 1, 2'b00, 2'd2, 2'd0, 2'd0, 3'b000, 0, 0);
      chk("zero_zf", 32'(out_zf[0]), 32'd1);
      chk("load_keeps_alu_a", 32'(alu_a[0]), 32'b111);

      // Backpressure with an ignored in_valid pulse
      issue(0, 1, 2'b00, 2'd0, 2'd0, 2'd0, 3'b101, 5, 1);
      issue(0, 0, 2'b01, 2'd1, 2'd2, 2'd0, 3'd0, 5, 1);

      // Self-source
      issue(0, 1, 2'b00, 2'd1, 2'd0, 2'd0, 3'b010, 0, 0);
      issue(0, 0, 2'b00, 2'd1, 2'd1, 2'd1, 3'd0, 0, 0);
      chk("self_out_r", 32'(out_r[0]), 32'b100);
      issue(0, 0, 2'b00, 2'd2, 2'd1, 2'd0, 3'd0, 0, 0);
      chk("self_next_alu_a", 32'(alu_a[0]), 32'b100);

      // Back-to-back ALU ops accepted every 3 cycles
      issue(0, 0, 2'b10, 2'd0, 2'd1, 2'd2, 3'd0, 0, 0);
      t0 = last_acc[0];
      issue(0, 0, 2'b11, 2'd3, 2'd0, 2'd1, 3'd0, 0, 0);
      chk("b2b_spacing", 32'(last_acc[0] - t0), 32'd30);

      // EXEC_CYCLES=4 instance
      issue(1, 1, 2'b00, 2'd0, 2'd0, 2'd0, 3'b110, 0, 0);
      issue(1, 1, 2'b00, 2'd1, 2'd0, 2'd0, 3'b011, 0, 0);
      issue(1, 0, 2'b00, 2'd2, 2'd0, 2'd1, 3'd0, 2, 0);
      issue(1, 0, 2'b01, 2'd3, 2'd1, 2'd0, 3'd0, 0, 0);

      // Randomized traffic
      for (int n = 0; n < 40; n++) begin
         int k;
         k = (n % 5 == 4) ? 1 : 0;
         issue(k, 1'($urandom_range(0, 2) == 0), 2'($urandom), 2'($urandom), 2'($urandom),
               2'($urandom), 3'($urandom), int'($urandom_range(0, 2)), 1'($urandom_range(0, 3) == 0));
      end

      // Reset in the middle of EXEC on the 4-cycle instance
      in_valid[1] = 1'b1; in_load[1] = 1'b0; in_op[1] = 2'b00;
      in_rd[1] = 2'd0; in_rs1[1] = 2'd1; in_rs2[1] = 2'd2;
      @(negedge clk);
      in_valid[1] = 1'b0;
      @(negedge clk);
      chk("mid_exec_busy", 32'(in_ready[1]), 32'd0);
      rst_n = 1'b0;
      model_reset();
      #1;
      check_reset_state("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("midrst_no_resp", 32'(out_valid[1]), 32'd0);
      check_dbg(1, 2'd0, "midrst_no_wb");
      issue(1, 1, 2'b00, 2'd2, 2'd0, 2'd0, 3'b001, 0, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
